// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the multi-port SRAM-to-AXI3 bridge: write FSM
// encodings, fixed AXI burst attributes and the port-count ceiling.
package axi_bridge_pkg;

  localparam int MAX_NPORT = 4;
  localparam int PIDX_W    = 2;

  typedef enum logic [2:0] {
    WS_IDLE    = 3'd0,
    WS_SEND    = 3'd1,
    WS_WAIT_AW = 3'd2,
    WS_WAIT_W  = 3'd3,
    WS_WAIT_B  = 3'd4
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic       AXI_SIZE_PAD   = 1'b0;

  // One-hot grant to port index; the highest set bit wins if several are set.
  function automatic logic [PIDX_W-1:0] oh2idx(input logic [MAX_NPORT-1:0] oh);
    logic [PIDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NPORT; i++) begin
      if (oh[i]) idx = PIDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_arb.sv
// Fixed-priority arbiter: one-hot grant to the highest-index requester.
module prio_arb #(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  // Scan upward so the last (highest) requester overwrites earlier ones.
  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_sram_bridge_mp.sv
// Multi-port SRAM-like to AXI3 bridge. Reads are single-beat, tracked per
// port, and may return out of order by id; writes run one at a time through
// a small FSM and only start when no reads are in flight.
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid never depends on ready, and payload is held stable
// while valid is high and ready is low.
module axi_sram_bridge_mp
  import axi_bridge_pkg::*;
#(
  parameter int NPORT    = 2,
  parameter int DW       = 32,
  parameter int MAX_OUTS = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NPORT-1:0]      sram_req,
  input  logic [NPORT-1:0]      sram_wr,
  input  logic [2*NPORT-1:0]    sram_size,
  input  logic [DW/8*NPORT-1:0] sram_wstrb,
  input  logic [32*NPORT-1:0]   sram_addr,
  input  logic [DW*NPORT-1:0]   sram_wdata,
  output logic [NPORT-1:0]      sram_addr_ok,
  output logic [NPORT-1:0]      sram_data_ok,
  output logic [DW*NPORT-1:0]   sram_rdata,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [DW-1:0]         rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [DW-1:0]         wdata,
  output logic [DW/8-1:0]       wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [2:0]            wr_state_o
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(MAX_OUTS + 1);

  wr_state_e          wr_state_q;
  logic               ar_valid_q, aw_valid_q, w_valid_q;
  logic [31:0]        ar_addr_q, w_addr_q;
  logic [1:0]         ar_size_q, w_size_q;
  logic [PIDX_W-1:0]  ar_port_q, w_port_q, r_id_q;
  logic [DW-1:0]      w_data_q, r_data_q;
  logic [SW-1:0]      w_strb_q;
  logic               r_done_q, b_done_q;
  logic [CW-1:0]      outs_q [NPORT];

  logic [NPORT-1:0]   rd_elig, rd_gnt, rd_take, wr_cand, wr_gnt, wr_take;
  logic [PIDX_W-1:0]  rd_idx, wr_idx;
  logic               ar_free, outs_zero;
  logic               unused_axi;

  assign unused_axi = ^{rresp, rlast, bid, bresp};

  // Read eligibility: a read request with credit left and no overlap with the pending write.
  always_comb begin
    rd_elig   = '0;
    outs_zero = 1'b1;
    for (int i = 0; i < NPORT; i++) begin
      rd_elig[i] = sram_req[i] && !sram_wr[i] && (outs_q[i] < CW'(MAX_OUTS)) &&
                   !((wr_state_q != WS_IDLE) && (sram_addr[32*i+3 +: 29] == w_addr_q[31:3]));
      if (outs_q[i] != '0) outs_zero = 1'b0;
    end
  end

  assign wr_cand = sram_req & sram_wr;

  prio_arb #(.N(NPORT)) u_rd_arb (.req_i(rd_elig), .gnt_o(rd_gnt));
  prio_arb #(.N(NPORT)) u_wr_arb (.req_i(wr_cand), .gnt_o(wr_gnt));

  // The AR slot frees in the same cycle its current request is handed off.
  assign ar_free = !ar_valid_q || arready;
  assign rd_take = rd_gnt & {NPORT{ar_free && resetn}};
  assign wr_take = wr_gnt & {NPORT{(wr_state_q == WS_IDLE) && outs_zero && !ar_valid_q && resetn}};
  assign rd_idx  = oh2idx(MAX_NPORT'(rd_gnt));
  assign wr_idx  = oh2idx(MAX_NPORT'(wr_gnt));

  assign sram_addr_ok = rd_take | wr_take;

  // AR slot: load on read accept, drain on the AR handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_size_q  <= '0;
      ar_port_q  <= '0;
    end else begin
      if (ar_valid_q && arready) ar_valid_q <= 1'b0;
      if (|rd_take) begin
        ar_valid_q <= 1'b1;
        ar_addr_q  <= sram_addr[32*rd_idx +: 32];
        ar_size_q  <= sram_size[2*rd_idx +: 2];
        ar_port_q  <= rd_idx;
      end
    end
  end

  // Per-port outstanding read counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NPORT; i++) outs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (rd_take[i] && !(rvalid && rid == 4'(i))) begin
          outs_q[i] <= outs_q[i] + 1'b1;
        end else if (!rd_take[i] && rvalid && rid == 4'(i) && outs_q[i] != '0) begin
          outs_q[i] <= outs_q[i] - 1'b1;
        end
      end
    end
  end

  // R capture: every beat is accepted; only ids that map to a port report back.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_done_q <= 1'b0;
      r_id_q   <= '0;
      r_data_q <= '0;
    end else begin
      r_done_q <= rvalid && (rid < 4'(NPORT));
      if (rvalid) begin
        r_id_q   <= rid[PIDX_W-1:0];
        r_data_q <= rdata;
      end
    end
  end

  // Write FSM: latch on accept, issue AW and W independently, wait for B.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_state_q <= WS_IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_done_q   <= 1'b0;
      w_addr_q   <= '0;
      w_size_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      w_port_q   <= '0;
    end else begin
      b_done_q <= 1'b0;
      case (wr_state_q)
        WS_IDLE: if (|wr_take) begin
          wr_state_q <= WS_SEND;
          aw_valid_q <= 1'b1;
          w_valid_q  <= 1'b1;
          w_addr_q   <= sram_addr[32*wr_idx +: 32];
          w_size_q   <= sram_size[2*wr_idx +: 2];
          w_data_q   <= sram_wdata[DW*wr_idx +: DW];
          w_strb_q   <= sram_wstrb[SW*wr_idx +: SW];
          w_port_q   <= wr_idx;
        end
        WS_SEND: begin
          if (awready && wready) begin
            wr_state_q <= WS_WAIT_B;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
          end else if (awready) begin
            wr_state_q <= WS_WAIT_W;
            aw_valid_q <= 1'b0;
          end else if (wready) begin
            wr_state_q <= WS_WAIT_AW;
            w_valid_q  <= 1'b0;
          end
        end
        WS_WAIT_AW: if (awready) begin
          wr_state_q <= WS_WAIT_B;
          aw_valid_q <= 1'b0;
        end
        WS_WAIT_W: if (wready) begin
          wr_state_q <= WS_WAIT_B;
          w_valid_q  <= 1'b0;
        end
        WS_WAIT_B: if (bvalid && bready) begin
          wr_state_q <= WS_IDLE;
          b_done_q   <= 1'b1;
        end
        default: wr_state_q <= WS_IDLE;
      endcase
    end
  end

  // Holding off B while an R for the same port lands keeps data_ok to one pulse per port per cycle.
  assign bready = (wr_state_q == WS_WAIT_B) && !(rvalid && rid == {2'b00, w_port_q});
  assign rready = 1'b1;

  // Response strobes: R and B completions decoded to their ports.
  always_comb begin
    sram_data_ok = '0;
    for (int i = 0; i < NPORT; i++) begin
      sram_data_ok[i] = (r_done_q && r_id_q == PIDX_W'(i)) || (b_done_q && w_port_q == PIDX_W'(i));
    end
  end

  assign sram_rdata = {NPORT{r_data_q}};

  assign arid    = {2'b00, ar_port_q};
  assign araddr  = ar_addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = {AXI_SIZE_PAD, ar_size_q};
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arvalid = ar_valid_q;

  assign awid    = {2'b00, w_port_q};
  assign awaddr  = w_addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = {AXI_SIZE_PAD, w_size_q};
  assign awburst = AXI_BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign awvalid = aw_valid_q;

  assign wid     = {2'b00, w_port_q};
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign wlast   = 1'b1;
  assign wvalid  = w_valid_q;

  assign wr_state_o = wr_state_q;

endmodule

// File: tb/tb_axi_sram_bridge_mp.sv
// Directed bench for axi_sram_bridge_mp with NPORT=2, DW=32, MAX_OUTS=4.
module tb_axi_sram_bridge_mp;
  import axi_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  sram_req, sram_wr, sram_addr_ok, sram_data_ok;
  logic [3:0]  sram_size;
  logic [7:0]  sram_wstrb;
  logic [63:0] sram_addr, sram_wdata, sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot, wr_state;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  wstrb;
  logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic        wlast, wvalid, wready, bvalid, bready;

  int n_vec = 0;
  int n_err = 0;

  axi_sram_bridge_mp #(.NPORT(2), .DW(32), .MAX_OUTS(4)) dut (
    .clk(clk), .resetn(resetn),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
    .sram_wstrb(sram_wstrb), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .wr_state_o(wr_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic set_rd(input int p, input logic [31:0] addr);
    sram_req[p] = 1'b1;
    sram_wr[p]  = 1'b0;
    sram_addr[32*p +: 32] = addr;
    sram_size[2*p +: 2]   = 2'd2;
  endtask

  task automatic set_wr(input int p, input logic [31:0] addr, input logic [31:0] data);
    sram_req[p] = 1'b1;
    sram_wr[p]  = 1'b1;
    sram_addr[32*p +: 32]  = addr;
    sram_wdata[32*p +: 32] = data;
    sram_wstrb[4*p +: 4]   = 4'hF;
    sram_size[2*p +: 2]    = 2'd2;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] data);
    rvalid = 1'b1;
    rid    = id;
    rdata  = data;
  endtask

  initial begin
    resetn = 1'b0;
    sram_req = '0; sram_wr = '0; sram_size = '0; sram_wstrb = '0;
    sram_addr = '0; sram_wdata = '0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1;
    bvalid = 1'b0; bid = '0; bresp = '0;

    // Reset state
    #12;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 1);
    chk("rst_data_ok", sram_data_ok, 0);
    chk("rst_rdata", sram_rdata, 0);
    chk("rst_state", wr_state, WS_IDLE);
    tick();
    resetn = 1'b1;
    tick();

    // Simultaneous reads: port 1 wins, port 0 follows on the next cycle
    set_rd(0, 32'h100);
    set_rd(1, 32'h200);
    arready = 1'b1;
    #1 chk("arb_p1_first", sram_addr_ok, 2'b10);
    tick();
    sram_req[1] = 1'b0;
    #1 chk("arb_arvalid1", arvalid, 1);
    chk("arb_arid1", arid, 1);
    chk("arb_araddr1", araddr, 32'h200);
    chk("arb_arsize", arsize, 3'd2);
    chk("arb_arburst", arburst, 2'b01);
    chk("arb_arlen", arlen, 0);
    chk("arb_p0_next", sram_addr_ok, 2'b01);
    tick();
    sram_req[0] = 1'b0;
    #1 chk("arb_arid0", arid, 0);
    chk("arb_araddr0", araddr, 32'h100);
    tick();
    #1 chk("arb_ar_drained", arvalid, 0);

    // Out-of-order R: id 1 then id 0
    r_beat(1, 32'hAAAA1111);
    tick();
    r_beat(0, 32'hBBBB0000);
    #1 chk("ooo_dok_p1", sram_data_ok, 2'b10);
    chk("ooo_rdata_p1", sram_rdata[63:32], 32'hAAAA1111);
    tick();
    rvalid = 1'b0;
    #1 chk("ooo_dok_p0", sram_data_ok, 2'b01);
    chk("ooo_rdata_p0", sram_rdata[31:0], 32'hBBBB0000);
    tick();
    #1 chk("ooo_dok_idle", sram_data_ok, 2'b00);

    // Outstanding limit on port 0 with R held back
    set_rd(0, 32'h400);
    for (int k = 0; k < 4; k++) begin
      #1 chk("lim_accept", sram_addr_ok, 2'b01);
      tick();
    end
    #1 chk("lim_block", sram_addr_ok, 2'b00);
    tick();
    #1 chk("lim_block2", sram_addr_ok, 2'b00);
    r_beat(0, 32'h11);
    #1 chk("lim_block_rbeat", sram_addr_ok, 2'b00);
    tick();
    rvalid = 1'b0;
    #1 chk("lim_reopen", sram_addr_ok, 2'b01);
    chk("lim_dok", sram_data_ok, 2'b01);
    tick();
    sram_req[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r_beat(0, 32'h20 + 32'(k));
      tick();
      #1 chk("drain_dok", sram_data_ok, 2'b01);
      chk("drain_rdata", sram_rdata[31:0], 32'h20 + 32'(k));
    end
    r_beat(3, 32'hFF);
    tick();
    rvalid = 1'b0;
    arready = 1'b0;
    #1 chk("rid3_no_dok", sram_data_ok, 2'b00);
    tick();

    // Write with RAW-stalled read, AW ahead of W, B held off by R for the write port
    set_wr(1, 32'h1000, 32'hDEADBEEF);
    #1 chk("wr_accept", sram_addr_ok, 2'b10);
    tick();
    set_rd(1, 32'h3000);
    set_rd(0, 32'h1004);
    arready = 1'b1;
    awready = 1'b1;
    #1 chk("wr_state_send", wr_state, WS_SEND);
    chk("wr_awvalid", awvalid, 1);
    chk("wr_wvalid", wvalid, 1);
    chk("wr_awaddr", awaddr, 32'h1000);
    chk("wr_awid", awid, 1);
    chk("wr_wid", wid, 1);
    chk("wr_wdata", wdata, 32'hDEADBEEF);
    chk("wr_wstrb", wstrb, 4'hF);
    chk("wr_awsize", awsize, 3'd2);
    chk("wr_wlast", wlast, 1);
    chk("raw_stall_p1_ok", sram_addr_ok, 2'b10);
    tick();
    sram_req[1] = 1'b0;
    awready = 1'b0;
    #1 chk("wr_state_wait_w", wr_state, WS_WAIT_W);
    chk("wr_aw_dropped", awvalid, 0);
    chk("wr_w_held", wvalid, 1);
    chk("rd_p1_arid", arid, 1);
    chk("rd_p1_araddr", araddr, 32'h3000);
    chk("raw_stall", sram_addr_ok, 2'b00);
    tick();
    sram_addr[31:0] = 32'h2000;
    #1 chk("raw_other_addr_ok", sram_addr_ok, 2'b01);
    tick();
    sram_addr[31:0] = 32'h1004;
    #1 chk("raw_stall_again", sram_addr_ok, 2'b00);
    chk("rd_2000_araddr", araddr, 32'h2000);
    chk("rd_2000_arid", arid, 0);
    tick();
    wready = 1'b1;
    #1 chk("wr_still_wait_w", wr_state, WS_WAIT_W);
    tick();
    wready = 1'b0;
    bvalid = 1'b1;
    r_beat(1, 32'h33333333);
    #1 chk("wr_state_wait_b", wr_state, WS_WAIT_B);
    chk("bready_blocked", bready, 0);
    chk("wr_w_dropped", wvalid, 0);
    tick();
    rvalid = 1'b0;
    #1 chk("bready_open", bready, 1);
    chk("r_p1_dok", sram_data_ok, 2'b10);
    chk("r_p1_rdata", sram_rdata[63:32], 32'h33333333);
    chk("raw_stall_wait_b", sram_addr_ok, 2'b00);
    tick();
    bvalid = 1'b0;
    #1 chk("wr_back_idle", wr_state, WS_IDLE);
    chk("b_p1_dok", sram_data_ok, 2'b10);
    chk("raw_release", sram_addr_ok, 2'b01);
    tick();
    sram_req[0] = 1'b0;
    arready = 1'b0;
    #1 chk("pre_rst_arvalid", arvalid, 1);
    chk("pre_rst_araddr", araddr, 32'h1004);

    // Reset mid-operation with two reads in flight
    resetn = 1'b0;
    set_rd(0, 32'h500);
    r_beat(0, 32'h77);
    #1 chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_addr_ok", sram_addr_ok, 2'b00);
    chk("mid_rst_data_ok", sram_data_ok, 2'b00);
    chk("mid_rst_bready", bready, 0);
    chk("mid_rst_rready", rready, 1);
    tick();
    #1 chk("mid_rst_hold_dok", sram_data_ok, 2'b00);
    tick();
    resetn = 1'b1;
    rvalid = 1'b0;
    sram_req = '0;
    #1 chk("post_rst_dok0", sram_data_ok, 2'b00);
    tick();
    #1 chk("post_rst_dok1", sram_data_ok, 2'b00);
    chk("post_rst_arvalid", arvalid, 0);

    // Counters cleared: a write is accepted immediately
    set_wr(1, 32'h5000, 32'h12345678);
    #1 chk("post_rst_wr_ok", sram_addr_ok, 2'b10);
    tick();
    sram_req[1] = 1'b0;
    awready = 1'b1;
    wready = 1'b1;
    #1 chk("post_rst_send", wr_state, WS_SEND);
    chk("post_rst_wdata", wdata, 32'h12345678);
    tick();
    awready = 1'b0;
    wready = 1'b0;
    bvalid = 1'b1;
    #1 chk("post_rst_wait_b", wr_state, WS_WAIT_B);
    chk("post_rst_bready", bready, 1);
    tick();
    bvalid = 1'b0;
    #1 chk("post_rst_b_dok", sram_data_ok, 2'b10);
    chk("post_rst_idle", wr_state, WS_IDLE);
    tick();
    #1 chk("post_rst_quiet", sram_data_ok, 2'b00);

    // Report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
